// File: rtl/tx_gearbox_66_64_if.sv
// rtl/tx_gearbox_66_64_if.sv - block-in / word-out handshake bundle for the 66b->64b TX gearbox
//
// Signals:
//   in_data   [65:0] block from encoder/scrambler: [1:0] sync header (bit 0 first), [65:2] payload
//   in_valid         in_data holds a block
//   in_ready         gearbox can accept a block this cycle
//   out_data  [63:0] registered line word toward the SERDES
//   out_valid        out_data holds 64 valid bits this cycle
// Modports: master = block source / word sink, slave = gearbox.

interface tx_gearbox_66_64_if;
    logic [65:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/tx_gearbox_66_64.sv
// rtl/tx_gearbox_66_64.sv - single-lane TX gearbox packing 66-bit blocks into 64-bit line words
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   gb          tx_gearbox_66_64_if.slave: in_data/in_valid/in_ready block input,
//               out_data/out_valid registered word output
//   fill_level  registered count of buffered bits (0..129), zero-extended to FILL_W
// Parameters:
//   REVERSE     0: out_data bit 0 is first on the line; 1: bit 63 is first on the line
//   FILL_W      width of fill_level, at least 8

module tx_gearbox_66_64 #(
    parameter bit REVERSE = 1'b0,
    parameter int FILL_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tx_gearbox_66_64_if.slave     gb,
    output logic [FILL_W-1:0]     fill_level
);

    // Bit 0 is the oldest buffered bit. Bits at or above fill are always zero,
    // which lets a new block be merged with a plain OR.
    logic [129:0] bit_buf;
    logic [7:0]   fill;

    logic         emit;
    logic         accept;
    logic [7:0]   resid;
    logic [129:0] buf_shift;
    logic [129:0] buf_next;
    logic [7:0]   fill_next;
    logic [63:0]  word;

    // fill < 128 bounds the post-emit residual to 63, so a 66-bit block always fits.
    assign gb.in_ready = (fill < 8'd128);
    assign fill_level  = FILL_W'(fill);

    always_comb begin
        emit      = (fill >= 8'd64);
        accept    = gb.in_valid && gb.in_ready;
        resid     = emit ? (fill - 8'd64) : fill;
        buf_shift = emit ? {64'b0, bit_buf[129:64]} : bit_buf;
        buf_next  = buf_shift;
        if (accept) begin
            buf_next = buf_shift | ({64'b0, gb.in_data} << resid);
        end
        fill_next = accept ? (resid + 8'd66) : resid;
        for (int i = 0; i < 64; i++) begin
            word[i] = REVERSE ? bit_buf[63 - i] : bit_buf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_buf      <= '0;
            fill         <= '0;
            gb.out_data  <= '0;
            gb.out_valid <= 1'b0;
        end else begin
            bit_buf <= buf_next;
            fill    <= fill_next;
            if (emit) begin
                gb.out_data  <= word;
                gb.out_valid <= 1'b1;
            end else begin
                gb.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/tx_gearbox_66_64.md
Name: tx_gearbox_66_64

Overview:
Single-lane TX gearbox that converts the 66-bit blocks from the encoder/scrambler stage into a continuous stream of 64-bit words for the SERDES. Each block is a 2-bit sync header plus a 64-bit scrambled payload.
The gearbox packs blocks into a bit buffer and emits 64 bits per cycle. Upstream is throttled through in_ready: one pause every 33 cycles in steady state (32 blocks in, 33 words out).
One instance is used per lane.

Parameters:
REVERSE, 0, 0: out_data bit 0 is the first bit on the line; 1: out_data is bit-reversed, so bit 63 is the first bit on the line.
FILL_W, 8, width of the fill_level status port. Must be ≥ 8.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst_n  input  1  reset; synchronous, active-low.
in_data  input  66  block: [1:0] sync header (bit 0 sent first), [65:2] payload.
in_valid  input  1  in_data holds a block.
in_ready  output  1  gearbox can accept a block this cycle.
out_data  output  64  registered line word.
out_valid  output  1  out_data holds 64 valid bits this cycle.
fill_level  output  FILL_W  registered count of buffered bits, 0..129.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Buffer and fill are cleared to 0.
  - out_data=0, out_valid=0, fill_level=0.
  - in_ready=1 in the cycle after reset.
  - Reset applied mid-stream discards all buffered bits; no partial word is emitted.
- Buffer:
  - 130-bit register, LSB-aligned; bit 0 is the oldest bit.
  - fill is the number of valid bits, 0..129.
- in_ready is combinational from registered state only: in_ready = (fill < 128). It does not depend on in_valid.
- Accept: a block is taken when in_valid && in_ready at a rising edge.
- Emit: at each rising edge where fill ≥ 64 (pre-edge value):
  - out_data <= buf[63:0] (bit-reversed if REVERSE=1), out_valid <= 1.
  - The buffer shifts right by 64.
  - Otherwise out_valid <= 0 and out_data holds its previous value.
- Same edge, emit and accept together:
  - Emit is computed first.
  - The residual r = fill−64 (if emitting) or fill (if not).
  - The new block is written at bit positions [r+65:r].
  - New fill = r + 66·accept.
- Overflow: cannot occur. fill < 128 guarantees r ≤ 63, so new fill ≤ 129. Verification asserts fill ≤ 129 always.
- Underflow: if fill < 64, out_valid=0 for that cycle (a bubble). No error flag; this only happens when upstream stalls.
- Latency: first block accepted at edge N → out_valid=1 with bits [63:0] of that block after edge N+1.
- Steady state with in_valid held at 1 from an empty buffer:
  - fill sequence: 0, 66, 68, …, 128, 64, 66, 68, …
  - in_ready=0 for exactly 1 cycle in every 33 (when fill=128).
  - out_valid=1 continuously from the second cycle onward.
- Data integrity: the concatenated out_data stream (word 0 first, LSB-first within each word) equals the concatenation of accepted in_data blocks (LSB-first), with no bit lost or duplicated.
- fill_level mirrors fill, zero-extended.
- No state machine beyond the fill counter; the counter is the state.

Test Plan:
- Reset, then one block in_data={64'hFEDCBA9876543210, 2'b01} with in_valid for one cycle:
  - one edge later: out_valid=0, fill_level=66.
  - next edge: out_valid=1, out_data=66'h{…}[63:0] = {62'h…3210 bits, 2'b01}, i.e. out_data[1:0]=2'b01, out_data[63:2]=payload[61:0].
  - then fill_level=2, out_valid=0.
- Continuous in_valid with incrementing payloads 0,1,2,… for 200 cycles:
  - in_ready low exactly on cycles 32, 65, 98, … (period 33 from the first acceptance).
  - out_valid stays 1 after the first word.
  - Reference-model bitstream compare passes.
- Stall upstream (in_valid=0) for 5 cycles at fill=100 → one word emitted, then fill=36, then out_valid=0 for the remaining stall cycles. Stream integrity holds after resuming.
- Assert rst_n=0 for one cycle at fill=128:
  - next cycle: fill_level=0, out_valid=0, in_ready=1.
  - the next accepted block appears at out_data[1:0] of the second word after it (latency 2 edges).
- REVERSE=1 with the block from scenario 1 → out_data[63:62]=2'b10 (bit-reversed header) on the first valid word.
- Random in_valid (50% duty) for 10k cycles → fill_level never exceeds 129, in_ready never high when fill ≥ 128, and bitstream integrity holds.
